// File: rtl/scalar_mult_ctrl.sv
// Montgomery-ladder sequencer for k*P over GF(2^N): drives the key scanner,
// issues INIT/STEP/FINAL commands to the point datapath, short-circuits k=0/1.
module scalar_mult_ctrl #(
   parameter int N     = 233,
   parameter int CNT_W = 8,
   parameter int WDOG  = N + 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   output logic             key_load,
   output logic             key_check,
   output logic             keyfind_en,
   output logic             keyscan_en,
   input  logic             ki,
   input  logic             key_first_found,
   input  logic [CNT_W-1:0] key_cnt,
   input  logic [1:0]       key_state,
   output logic             op_start,
   output logic [1:0]       op_code,
   output logic             op_bit,
   input  logic             op_done,
   output logic             busy,
   output logic             done,
   output logic             result_inf,
   output logic             result_is_p,
   output logic             err
);

   localparam int WD_W = $clog2(WDOG + 1);

   localparam logic [4:0] S_IDLE      = 5'd0;
   localparam logic [4:0] S_LOAD      = 5'd1;
   localparam logic [4:0] S_CHECK     = 5'd2;
   localparam logic [4:0] S_JW        = 5'd3;
   localparam logic [4:0] S_JUDGE     = 5'd4;
   localparam logic [4:0] S_FIND      = 5'd5;
   localparam logic [4:0] S_FIND_WAIT = 5'd6;
   localparam logic [4:0] S_INIT      = 5'd7;
   localparam logic [4:0] S_OPW_I     = 5'd8;
   localparam logic [4:0] S_CHK       = 5'd9;
   localparam logic [4:0] S_SCAN      = 5'd10;
   localparam logic [4:0] S_SW1       = 5'd11;
   localparam logic [4:0] S_SW2       = 5'd12;
   localparam logic [4:0] S_STEP      = 5'd13;
   localparam logic [4:0] S_OPW_S     = 5'd14;
   localparam logic [4:0] S_FIN       = 5'd15;
   localparam logic [4:0] S_OPW_F     = 5'd16;
   localparam logic [4:0] S_DONE      = 5'd17;

   localparam logic [1:0] OP_INIT  = 2'b00;
   localparam logic [1:0] OP_STEP  = 2'b01;
   localparam logic [1:0] OP_FINAL = 2'b10;

   logic [4:0]      state_q, state_d;
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic [1:0]      code_q, code_d;
   logic            bit_q, bit_d;
   logic            inf_q, inf_d;
   logic            isp_q, isp_d;
   logic            err_q, err_d;
   logic            load_q, check_q, find_q, scan_q, opst_q, busy_q, done_q;

   always_comb begin
      state_d = state_q;
      wdog_d  = wdog_q;
      code_d  = code_q;
      bit_d   = bit_q;
      inf_d   = inf_q;
      isp_d   = isp_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               inf_d   = 1'b0;
               isp_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         S_LOAD:  state_d = S_CHECK;
         S_CHECK: state_d = S_JW;
         S_JW:    state_d = S_JUDGE;
         S_JUDGE: begin
            case (key_state)
               2'b01: begin inf_d = 1'b1; state_d = S_DONE; end
               2'b11: begin isp_d = 1'b1; state_d = S_DONE; end
               2'b10: begin err_d = 1'b1; state_d = S_DONE; end
               default: state_d = S_FIND;
            endcase
         end
         S_FIND: begin
            wdog_d  = '0;
            state_d = S_FIND_WAIT;
         end
         // The watchdog expires after exactly WDOG cycles spent in FIND_WAIT.
         S_FIND_WAIT: begin
            if (key_first_found) begin
               state_d = S_INIT;
            end else if (wdog_q == WD_W'(WDOG - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_INIT:  state_d = S_OPW_I;
         S_OPW_I: if (op_done) state_d = S_CHK;
         S_CHK:   state_d = (key_cnt == CNT_W'(N)) ? S_FIN : S_SCAN;
         S_SCAN:  state_d = S_SW1;
         S_SW1:   state_d = S_SW2;
         S_SW2: begin
            bit_d   = ki;
            state_d = S_STEP;
         end
         S_STEP:  state_d = S_OPW_S;
         S_OPW_S: if (op_done) state_d = S_CHK;
         S_FIN:   state_d = S_OPW_F;
         S_OPW_F: if (op_done) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Opcode is loaded on entry to a command state and held until the next one.
      if (state_d == S_INIT) code_d = OP_INIT;
      if (state_d == S_STEP) code_d = OP_STEP;
      if (state_d == S_FIN)  code_d = OP_FINAL;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         wdog_q  <= '0;
         code_q  <= OP_INIT;
         bit_q   <= 1'b0;
         inf_q   <= 1'b0;
         isp_q   <= 1'b0;
         err_q   <= 1'b0;
         load_q  <= 1'b0;
         check_q <= 1'b0;
         find_q  <= 1'b0;
         scan_q  <= 1'b0;
         opst_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
         code_q  <= code_d;
         bit_q   <= bit_d;
         inf_q   <= inf_d;
         isp_q   <= isp_d;
         err_q   <= err_d;
         load_q  <= (state_d == S_LOAD);
         check_q <= (state_d == S_CHECK);
         find_q  <= (state_d == S_FIND);
         scan_q  <= (state_d == S_SCAN);
         opst_q  <= (state_d == S_INIT) || (state_d == S_STEP) || (state_d == S_FIN);
         busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign key_load    = load_q;
   assign key_check   = check_q;
   assign keyfind_en  = find_q;
   assign keyscan_en  = scan_q;
   assign op_start    = opst_q;
   assign op_code     = code_q;
   assign op_bit      = bit_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign result_inf  = inf_q;
   assign result_is_p = isp_q;
   assign err         = err_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl with a behavioural key scanner and a fixed-latency
// datapath responder; expected command streams are queued per run.
module tb_scalar_mult_ctrl;

   localparam int N     = 8;
   localparam int CNT_W = 8;
   localparam int WDOG  = N + 4;

   logic             CLK = 1'b0;
   logic             RST_N = 1'b0;
   logic             start = 1'b0;
   logic             key_load, key_check, keyfind_en, keyscan_en;
   logic             ki = 1'b0;
   logic             key_first_found = 1'b0;
   logic [CNT_W-1:0] key_cnt = '0;
   logic [1:0]       key_state = 2'b00;
   logic             op_start;
   logic [1:0]       op_code;
   logic             op_bit;
   logic             op_done = 1'b0;
   logic             busy, done, result_inf, result_is_p, err;

   scalar_mult_ctrl #(.N(N), .CNT_W(CNT_W), .WDOG(WDOG)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start),
      .key_load(key_load), .key_check(key_check),
      .keyfind_en(keyfind_en), .keyscan_en(keyscan_en),
      .ki(ki), .key_first_found(key_first_found),
      .key_cnt(key_cnt), .key_state(key_state),
      .op_start(op_start), .op_code(op_code), .op_bit(op_bit), .op_done(op_done),
      .busy(busy), .done(done), .result_inf(result_inf),
      .result_is_p(result_is_p), .err(err)
   );

   always #5 CLK = ~CLK;

   int nvec = 0;
   int nmis = 0;

   logic [7:0] key_val = 8'h00;
   bit         stall = 1'b0;
   bit         stray_req = 1'b0;

   logic [2:0] obs_q[$];
   logic [2:0] exp_q[$];
   int         cyc = 0, op_cnt = 0, find_cnt = 0, done_cnt = 0;
   int         overlap = 0, hold_bad = 0, find_cyc = 0, done_cyc = 0;
   logic       done_busy = 1'b0;

   // Monitor, datapath responder and key scanner share one process so their
   // per-negedge ordering is fixed: observe first, then update DUT inputs.
   initial begin
      logic [7:0] sh;
      bit         searching;
      bit         pend;
      logic [2:0] pend_v;
      int         dp_cnt;
      sh = '0; searching = 0; pend = 0; pend_v = '0; dp_cnt = 0;
      forever begin
         @(negedge CLK);
         cyc++;
         if ($countones({key_load, key_check, keyfind_en, keyscan_en}) > 1) overlap++;
         if (op_start) begin
            obs_q.push_back({op_code, op_bit});
            op_cnt++;
            pend   = 1;
            pend_v = {op_code, op_bit};
         end else if (pend && ({op_code, op_bit} !== pend_v)) begin
            hold_bad++;
         end
         if (op_done) pend = 0;
         if (keyfind_en) begin find_cnt++; find_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end

         op_done = 1'b0;
         if (!RST_N) begin
            dp_cnt = 0;
            pend   = 0;
         end else begin
            if (dp_cnt != 0) begin
               dp_cnt--;
               if (dp_cnt == 0) op_done = 1'b1;
            end
            if (op_start) dp_cnt = 3;
            if (stray_req) op_done = 1'b1;
         end

         if (!RST_N) begin
            sh = '0; searching = 0; ki = 1'b0; key_first_found = 1'b0;
            key_cnt = '0; key_state = 2'b00;
         end else begin
            if (key_load) begin
               sh = key_val; searching = 0; key_first_found = 1'b0;
               key_cnt = '0; key_state = 2'b00;
            end
            if (key_check)
               key_state = (sh == 8'h00) ? 2'b01 : ((sh == 8'h01) ? 2'b11 : 2'b00);
            if (keyfind_en) searching = 1;
            if (keyscan_en) begin
               ki = sh[7]; sh = sh << 1; key_cnt = key_cnt + 1'b1;
            end else if (searching && !stall) begin
               key_cnt = key_cnt + 1'b1;
               if (sh[7]) begin key_first_found = 1'b1; searching = 0; end
               sh = sh << 1;
            end
         end
      end
   end

   task automatic tick;
      @(negedge CLK);
      #1;
   endtask

   task automatic clear_obs;
      obs_q.delete(); exp_q.delete();
      op_cnt = 0; find_cnt = 0; done_cnt = 0; overlap = 0; hold_bad = 0;
   endtask

   task automatic build_exp(input logic [7:0] k, output int nops);
      int m;
      m = 0;
      for (int i = 0; i < N; i++) if (k[i]) m = i;
      exp_q.push_back(3'b000);
      for (int i = m - 1; i >= 0; i--) exp_q.push_back({2'b01, k[i]});
      exp_q.push_back(3'b100);
      nops = m + 2;
   endtask

   task automatic launch(input logic [7:0] k);
      key_val = k;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output bit ok);
      for (int i = 0; i < lim && done_cnt == 0; i++) tick;
      ok = (done_cnt != 0);
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      repeat (3) tick;
      nvec++;
      if ({key_load, key_check, keyfind_en, keyscan_en, op_start, op_code, op_bit,
           busy, done, result_inf, result_is_p, err} !== 13'd0) begin
         nmis++;
         $display("FAIL reset_outputs: got %b required 0", {key_load, key_check, keyfind_en,
                  keyscan_en, op_start, op_code, op_bit, busy, done, result_inf, result_is_p, err});
      end
      RST_N = 1'b1;
      tick;
   endtask

   task automatic test_special(input logic [7:0] k, input logic exp_inf, input logic exp_p);
      bit ok;
      clear_obs;
      launch(k);
      wait_done(60, ok);
      repeat (3) tick;
      nvec++;
      if (!ok) begin nmis++; $display("FAIL special_%0h_timeout: no done pulse", k); end
      nvec++;
      if (result_inf !== exp_inf || result_is_p !== exp_p || err !== 1'b0) begin
         nmis++;
         $display("FAIL special_%0h_flags: got inf=%b p=%b err=%b required inf=%b p=%b err=0",
                  k, result_inf, result_is_p, err, exp_inf, exp_p);
      end
      nvec++;
      if (op_cnt !== 0 || find_cnt !== 0) begin
         nmis++;
         $display("FAIL special_%0h_no_ops: got op_start=%0d keyfind=%0d required 0 0", k, op_cnt, find_cnt);
      end
      nvec++;
      if (done_cnt !== 1 || done_busy !== 1'b0 || busy !== 1'b0) begin
         nmis++;
         $display("FAIL special_%0h_done: got done_cnt=%0d busy_at_done=%b required 1 0", k, done_cnt, done_busy);
      end
   endtask

   task automatic test_ladder(input logic [7:0] k);
      bit ok;
      int nops;
      logic [2:0] e, o;
      clear_obs;
      build_exp(k, nops);
      launch(k);
      wait_done(400, ok);
      repeat (3) tick;
      nvec++;
      if (!ok) begin nmis++; $display("FAIL ladder_%0h_timeout: no done pulse", k); end
      nvec++;
      if (op_cnt !== nops) begin
         nmis++;
         $display("FAIL ladder_%0h_opcount: got %0d required %0d", k, op_cnt, nops);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         nvec++;
         if (obs_q.size() == 0) begin
            nmis++;
            $display("FAIL ladder_%0h_op: got none required code=%b bit=%b", k, e[2:1], e[0]);
         end else begin
            o = obs_q.pop_front();
            if (o[2:1] !== e[2:1] || (e[2:1] == 2'b01 && o[0] !== e[0])) begin
               nmis++;
               $display("FAIL ladder_%0h_op: got code=%b bit=%b required code=%b bit=%b",
                        k, o[2:1], o[0], e[2:1], e[0]);
            end
         end
      end
      nvec++;
      if (done_cnt !== 1 || err !== 1'b0 || result_inf !== 1'b0 || result_is_p !== 1'b0 || busy !== 1'b0) begin
         nmis++;
         $display("FAIL ladder_%0h_end: got done_cnt=%0d err=%b inf=%b p=%b busy=%b required 1 0 0 0 0",
                  k, done_cnt, err, result_inf, result_is_p, busy);
      end
      nvec++;
      if (overlap !== 0 || hold_bad !== 0) begin
         nmis++;
         $display("FAIL ladder_%0h_strobes: got overlap=%0d unstable_cmd=%0d required 0 0", k, overlap, hold_bad);
      end
   endtask

   task automatic test_watchdog;
      bit ok;
      clear_obs;
      stall = 1'b1;
      launch(8'h2D);
      wait_done(200, ok);
      tick;
      nvec++;
      if (!ok) begin nmis++; $display("FAIL watchdog_timeout: no done pulse"); end
      nvec++;
      if (done_cyc - find_cyc !== WDOG + 1) begin
         nmis++;
         $display("FAIL watchdog_latency: got %0d cycles after FIND_WAIT entry required %0d",
                  done_cyc - find_cyc - 1, WDOG);
      end
      nvec++;
      if (err !== 1'b1 || done_busy !== 1'b0 || op_cnt !== 0) begin
         nmis++;
         $display("FAIL watchdog_flags: got err=%b busy_at_done=%b ops=%0d required 1 0 0", err, done_busy, op_cnt);
      end
      stall = 1'b0;
   endtask

   task automatic test_start_ignored;
      bit ok;
      int nops;
      logic [2:0] e, o;
      int bad;
      clear_obs;
      build_exp(8'h2D, nops);
      launch(8'h2D);
      for (int i = 0; i < 100 && op_cnt < 3; i++) tick;
      start = 1'b1;
      tick;
      start = 1'b0;
      wait_done(400, ok);
      repeat (10) tick;
      nvec++;
      if (!ok) begin nmis++; $display("FAIL start_ignored_timeout: no done pulse"); end
      bad = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) bad++;
         else begin
            o = obs_q.pop_front();
            if (o[2:1] !== e[2:1] || (e[2:1] == 2'b01 && o[0] !== e[0])) bad++;
         end
      end
      nvec++;
      if (bad != 0 || op_cnt !== nops) begin
         nmis++;
         $display("FAIL start_ignored_ops: got %0d bad ops of %0d issued required 0 of %0d", bad, op_cnt, nops);
      end
      nvec++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         nmis++;
         $display("FAIL start_ignored_restart: got done_cnt=%0d busy=%b required 1 0", done_cnt, busy);
      end
   endtask

   task automatic test_reset_mid;
      clear_obs;
      launch(8'h2D);
      for (int i = 0; i < 100 && op_cnt < 2; i++) tick;
      tick;
      RST_N = 1'b0;
      tick;
      nvec++;
      if ({key_load, key_check, keyfind_en, keyscan_en, op_start, op_code, op_bit,
           busy, done, result_inf, result_is_p, err} !== 13'd0) begin
         nmis++;
         $display("FAIL reset_mid_outputs: got %b required 0", {key_load, key_check, keyfind_en,
                  keyscan_en, op_start, op_code, op_bit, busy, done, result_inf, result_is_p, err});
      end
      RST_N = 1'b1;
      repeat (10) tick;
      nvec++;
      if (done_cnt !== 0 || busy !== 1'b0 || op_cnt !== 2) begin
         nmis++;
         $display("FAIL reset_mid_abort: got done_cnt=%0d busy=%b ops=%0d required 0 0 2", done_cnt, busy, op_cnt);
      end
   endtask

   task automatic test_stray_done;
      int act;
      clear_obs;
      act = 0;
      stray_req = 1'b1;
      tick;
      stray_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (busy || op_start || done || key_load) act++;
      end
      nvec++;
      if (act !== 0 || done_cnt !== 0) begin
         nmis++;
         $display("FAIL stray_done: got %0d active cycles done_cnt=%0d required 0 0", act, done_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_special(8'h00, 1'b1, 1'b0);
      test_special(8'h01, 1'b0, 1'b1);
      test_ladder(8'h2D);
      test_ladder(8'h80);
      test_ladder(8'hFF);
      test_watchdog;
      test_start_ignored;
      test_reset_mid;
      test_ladder(8'h2D);
      test_stray_done;
      test_special(8'h01, 1'b0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
- Montgomery-ladder sequencer for ECC scalar multiplication k·P over GF(2^N).
- Sits directly downstream of the key scanner. It drives the scanner's load/check/find/scan strobes and consumes its ki, key_first_found, key_cnt and key_state outputs.
- Issues one command per ladder operation to the point-arithmetic datapath over a start/done handshake.
- Short-circuits k=0 and k=1 without touching the datapath.

Parameters:
- N, 233, scalar width; must match the scanner.
- CNT_W, 8, width of key_cnt; must satisfy 2^CNT_W > N.
- WDOG, N+4, maximum cycles allowed in FIND_WAIT before an error is flagged.

Ports:
- CLK  input  1  clock
- RST_N  input  1  synchronous, active-low reset
- start  input  1  one-cycle request; ignored while busy=1
- key_load  output  1  scanner load strobe
- key_check  output  1  scanner pre-judge strobe
- keyfind_en  output  1  scanner find-first-one strobe
- keyscan_en  output  1  scanner next-bit strobe
- ki  input  1  current scalar bit from the scanner
- key_first_found  input  1  scanner found the MSB one
- key_cnt  input  CNT_W  bits consumed by the scanner
- key_state  input  2  00 normal, 01 k=0, 11 k=1
- op_start  output  1  one-cycle datapath command strobe
- op_code  output  2  00 INIT (X1=P, X2=2P), 01 STEP, 10 FINAL (affine/y recovery)
- op_bit  output  1  ladder bit for STEP
- op_done  input  1  one-cycle datapath completion
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- result_inf  output  1  result is the point at infinity (k=0)
- result_is_p  output  1  result equals P (k=1)
- err  output  1  watchdog fired

Behaviour:
- Reset: all outputs 0, op_code=00, state IDLE. Reset mid-operation aborts immediately with no done pulse; the scanner shares RST_N.
- All strobes are registered one-cycle pulses. At most one scanner strobe is asserted in any cycle.
- States and transitions:
  - IDLE: on start → LOAD; clear result_inf, result_is_p, err; set busy.
  - LOAD: key_load=1 → CHECK.
  - CHECK: key_check=1 → JW.
  - JW: wait 1 cycle for the scanner pre-judge → JUDGE.
  - JUDGE: sample key_state.
    - 01: set result_inf → DONE.
    - 11: set result_is_p → DONE.
    - 00: → FIND.
    - 10: set err → DONE.
  - FIND: keyfind_en=1; clear watchdog → FIND_WAIT.
  - FIND_WAIT: wait for key_first_found=1 → INIT. Watchdog increments each cycle; when it reaches WDOG, set err → DONE.
  - INIT: op_start=1, op_code=00 → OPW_I.
  - OPW_I: on op_done → CHK.
  - CHK: if key_cnt==N → FIN; else → SCAN.
  - SCAN: keyscan_en=1 → SW1.
  - SW1 → SW2: scanner shifts.
  - SW2: latch ki into op_bit → STEP.
  - STEP: op_start=1, op_code=01 → OPW_S.
  - OPW_S: on op_done → CHK.
  - FIN: op_start=1, op_code=10 → OPW_F.
  - OPW_F: on op_done → DONE.
  - DONE: done=1, busy=0 → IDLE.
- The result flags hold until the next accepted start.
- op_done is sampled only in OPW_* states, from the cycle after op_start. Stray op_done is ignored.
- op_bit and op_code are held stable from op_start until op_done.
- start during busy, including the DONE cycle, is ignored.
- Total datapath commands for a normal k = 1 + (N − key_cnt after find) + 1.
- key_cnt is compared unsigned at full CNT_W width; no wrap is possible since 2^CNT_W > N.

Test Plan:
- N=8, k=0x00 → key_state=01 seen in JUDGE; done with result_inf=1, result_is_p=0; zero op_start pulses; keyfind_en never asserted.
- N=8, k=0x01 → result_is_p=1, done; zero op_start pulses.
- N=8, k=0x2D, op_done returned 3 cycles after each op_start → key_cnt=3 after find; ops INIT, then STEP with op_bit 0,1,1,0,1, then FINAL; exactly 7 op_start pulses, then done=1, err=0.
- N=8, k=0x80 and k=0xFF → 1 INIT, 7 STEPs (op_bit all 0 / all 1 respectively), 1 FINAL. Check that no two scanner strobes ever overlap.
- Stall the scanner (key_first_found never asserts) → err=1 and done pulse exactly WDOG cycles after FIND_WAIT entry; busy drops the same cycle.
- start pulsed mid-STEP is ignored. RST_N low during OPW_S → next cycle all outputs 0, no done. A fresh start afterwards with k=0x2D completes correctly. Stray op_done in IDLE causes no state change.
